// File: rtl/calc_pkg.sv
// calc_pkg: shared types and constants for the signed divide controller.
//   state_t    : controller FSM state encoding
//   DEF_DW     : default operand / result width
//   calc_cnt_w : width of the iteration counter for a given operand width
//   CNT_W      : iteration counter width at the default operand width
package calc_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DIV  = 2'd1,
      ST_FIX  = 2'd2
   } state_t;

   localparam int unsigned DEF_DW = 8;

   // Counter only needs to reach dw-1.
   function automatic int unsigned calc_cnt_w(input int unsigned dw);
      return (dw <= 2) ? 1 : $clog2(dw);
   endfunction

   localparam int unsigned CNT_W = calc_cnt_w(DEF_DW);

endpackage

// File: rtl/calc_rr_arb.sv
// calc_rr_arb: two-way round-robin arbiter.
//   clk, rst_n : clock, synchronous active-low reset
//   req        : request vector, bit i from requester i
//   advance    : strobe marking that the current grant was taken
//   grant_c    : combinational one-hot grant (zero when no request)
module calc_rr_arb
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] grant_c
);

   // Requester favoured when both request together.
   logic ptr;

   always_comb begin
      grant_c = 2'b00;
      case (req)
         2'b01:   grant_c = 2'b01;
         2'b10:   grant_c = 2'b10;
         2'b11:   grant_c = ptr ? 2'b10 : 2'b01;
         default: grant_c = 2'b00;
      endcase
   end

   // After serving requester 0 favour 1, and vice versa.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ptr <= 1'b0;
      end else if (advance && (grant_c != 2'b00)) begin
         ptr <= grant_c[0];
      end
   end

endmodule

// File: rtl/calc_div_ctrl.sv
// calc_div_ctrl: shared signed divider serving two requesters.
//   clk, rst_n    : clock, synchronous active-low reset
//   req[1:0]      : requests, held until the matching gnt bit
//   a0/b0, a1/b1  : signed dividend / divisor of requester 0 / 1
//   gnt[1:0]      : one-cycle one-hot accept pulse
//   busy          : division in progress (state not IDLE)
//   done          : one-cycle result-valid pulse
//   done_id       : requester owning the result
//   q, r          : signed quotient / remainder
//   div0, ovf     : divide-by-zero / overflow flags
module calc_div_ctrl
   import calc_pkg::*;
#(
   parameter int unsigned DW = DEF_DW
)
(
   input  logic          clk,
   input  logic          rst_n,
   input  logic [1:0]    req,
   input  logic [DW-1:0] a0,
   input  logic [DW-1:0] b0,
   input  logic [DW-1:0] a1,
   input  logic [DW-1:0] b1,
   output logic [1:0]    gnt,
   output logic          busy,
   output logic          done,
   output logic          done_id,
   output logic [DW-1:0] q,
   output logic [DW-1:0] r,
   output logic          div0,
   output logic          ovf
);

   localparam int unsigned CW = calc_cnt_w(DW);
   localparam logic [DW-1:0] MAX_POS = {1'b0, {(DW-1){1'b1}}};

   state_t        state;
   logic [DW:0]   prem;      // partial remainder
   logic [DW-1:0] qacc;      // dividend shifts out, quotient bits shift in
   logic [DW-1:0] mag_b;
   logic          sign_a;
   logic          sign_b;
   logic          zero_b;
   logic          owner;
   logic [CW-1:0] cnt;

   logic [1:0]    win_c;
   logic          adv_c;
   logic [DW-1:0] sel_a_c;
   logic [DW-1:0] sel_b_c;
   logic [DW-1:0] mag_a_c;
   logic [DW-1:0] mag_b_c;
   logic [DW:0]   shifted_c;
   logic          take_c;
   logic          qneg_c;
   logic [DW-1:0] qfix_c;
   logic [DW-1:0] rfix_c;
   logic          ovf_c;

   assign adv_c = (state == ST_IDLE) && (req != 2'b00);

   calc_rr_arb u_arb (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req),
      .advance (adv_c),
      .grant_c (win_c)
   );

   // Winner operands and magnitudes; -2^(DW-1) maps to unsigned 2^(DW-1).
   always_comb begin
      sel_a_c = win_c[1] ? a1 : a0;
      sel_b_c = win_c[1] ? b1 : b0;
      mag_a_c = sel_a_c[DW-1] ? DW'(-sel_a_c) : sel_a_c;
      mag_b_c = sel_b_c[DW-1] ? DW'(-sel_b_c) : sel_b_c;
   end

   // One restoring shift-subtract step.
   always_comb begin
      shifted_c = {prem[DW-1:0], qacc[DW-1]};
      take_c    = (shifted_c >= {1'b0, mag_b});
   end

   // Sign fix-up. With B==0 every step subtracts zero, so prem ends up
   // holding |A| and r = A falls out of the normal remainder path.
   always_comb begin
      qneg_c = (sign_a ^ sign_b) && (qacc != '0);
      qfix_c = qneg_c ? DW'(-qacc) : qacc;
      rfix_c = sign_a ? DW'(-prem[DW-1:0]) : prem[DW-1:0];
      // Only -2^(DW-1) / -1 yields a same-sign quotient with the MSB set.
      ovf_c  = !zero_b && (sign_a == sign_b) && qacc[DW-1];
   end

   // Controller FSM with registered outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         gnt     <= 2'b00;
         busy    <= 1'b0;
         done    <= 1'b0;
         done_id <= 1'b0;
         q       <= '0;
         r       <= '0;
         div0    <= 1'b0;
         ovf     <= 1'b0;
         prem    <= '0;
         qacc    <= '0;
         mag_b   <= '0;
         sign_a  <= 1'b0;
         sign_b  <= 1'b0;
         zero_b  <= 1'b0;
         owner   <= 1'b0;
         cnt     <= '0;
      end else begin
         gnt  <= 2'b00;
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (req != 2'b00) begin
                  gnt    <= win_c;
                  owner  <= win_c[1];
                  sign_a <= sel_a_c[DW-1];
                  sign_b <= sel_b_c[DW-1];
                  zero_b <= (sel_b_c == '0);
                  qacc   <= mag_a_c;
                  mag_b  <= mag_b_c;
                  prem   <= '0;
                  cnt    <= '0;
                  busy   <= 1'b1;
                  state  <= ST_DIV;
               end
            end
            ST_DIV: begin
               prem <= take_c ? (shifted_c - {1'b0, mag_b}) : shifted_c;
               qacc <= {qacc[DW-2:0], take_c};
               cnt  <= cnt + CW'(1);
               if (cnt == CW'(DW-1)) begin
                  state <= ST_FIX;
               end
            end
            ST_FIX: begin
               if (zero_b) begin
                  q <= '0;
               end else if (ovf_c) begin
                  q <= MAX_POS;
               end else begin
                  q <= qfix_c;
               end
               r       <= rfix_c;
               div0    <= zero_b;
               ovf     <= ovf_c;
               done_id <= owner;
               done    <= 1'b1;
               busy    <= 1'b0;
               state   <= ST_IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_calc_div_ctrl.sv
// tb_calc_div_ctrl: directed self-checking bench for calc_div_ctrl (DW=8).
module tb_calc_div_ctrl;

   logic       clk;
   logic       rst_n;
   logic [1:0] req;
   logic [7:0] a0, b0, a1, b1;
   logic [1:0] gnt;
   logic       busy, done, done_id;
   logic [7:0] q, r;
   logic       div0, ovf;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   calc_div_ctrl #(.DW(8)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req),
      .a0      (a0),
      .b0      (b0),
      .a1      (a1),
      .b1      (b1),
      .gnt     (gnt),
      .busy    (busy),
      .done    (done),
      .done_id (done_id),
      .q       (q),
      .r       (r),
      .div0    (div0),
      .ovf     (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // Wait (bounded) for a grant pulse; sampled 1 time unit after the edge.
   task automatic wait_gnt(output int n);
      n = 0;
      while (gnt == 2'b00 && n < 30) begin
         @(posedge clk); #1; n++;
      end
   endtask

   // Wait (bounded) for done; n is cycles counted from the grant.
   task automatic wait_done(output int n);
      n = 0;
      while (!done && n < 30) begin
         @(posedge clk); #1; n++;
      end
   endtask

   task automatic run_op(input string tag, input int id,
                         input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] eq, input logic [7:0] er,
                         input logic ediv0, input logic eovf);
      int n;
      logic [1:0] ereq;
      @(negedge clk);
      if (id == 0) begin a0 = a; b0 = b; end
      else         begin a1 = a; b1 = b; end
      ereq = (id == 0) ? 2'b01 : 2'b10;
      req  = ereq;
      wait_gnt(n);
      chk({tag, " gnt"}, 32'(gnt), 32'(ereq));
      req = 2'b00;
      @(posedge clk); #1;
      chk({tag, " busy"}, 32'(busy), 32'd1);
      wait_done(n);
      chk({tag, " latency"}, 32'(n + 1), 32'd9);
      chk({tag, " q"}, 32'(q), 32'(eq));
      chk({tag, " r"}, 32'(r), 32'(er));
      chk({tag, " div0"}, 32'(div0), 32'(ediv0));
      chk({tag, " ovf"}, 32'(ovf), 32'(eovf));
      chk({tag, " done_id"}, 32'(done_id), 32'(id));
      chk({tag, " busy_done"}, 32'(busy), 32'd0);
   endtask

   initial begin
      int n;
      int prev;
      int ndone;
      logic [1:0] eg;

      rst_n = 1'b0;
      req   = 2'b00;
      a0 = 8'd0; b0 = 8'd0; a1 = 8'd0; b1 = 8'd0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst gnt",  32'(gnt),  32'd0);
      chk("rst busy", 32'(busy), 32'd0);
      chk("rst done", 32'(done), 32'd0);
      chk("rst q",    32'(q),    32'd0);
      chk("rst r",    32'(r),    32'd0);
      rst_n = 1'b1;

      // Basic and sign combinations
      run_op("p100_7",   0, 8'd100,      8'd7,       8'h0E, 8'h02, 1'b0, 1'b0);
      run_op("n100_7",   1, 8'(-100),    8'd7,       8'hF2, 8'hFE, 1'b0, 1'b0);
      run_op("p100_n7",  1, 8'd100,      8'(-7),     8'hF2, 8'h02, 1'b0, 1'b0);
      run_op("n100_n7",  1, 8'(-100),    8'(-7),     8'h0E, 8'hFE, 1'b0, 1'b0);
      // Edge cases
      run_op("div_zero", 0, 8'd5,        8'd0,       8'h00, 8'h05, 1'b1, 1'b0);
      run_op("ovf",      0, 8'h80,       8'hFF,      8'h7F, 8'h00, 1'b0, 1'b1);
      run_op("min_by_1", 1, 8'h80,       8'd1,       8'h80, 8'h00, 1'b0, 1'b0);

      // Continuous dual request: grants alternate, 10 cycles apart
      @(negedge clk);
      a0 = 8'd100; b0 = 8'd7; a1 = 8'(-100); b1 = 8'd7;
      req = 2'b11;
      prev = 0;
      for (int k = 0; k < 4; k++) begin
         eg = (k % 2 == 0) ? 2'b01 : 2'b10;
         wait_gnt(n);
         chk($sformatf("rr gnt%0d", k), 32'(gnt), 32'(eg));
         if (k > 0) chk($sformatf("rr spacing%0d", k), 32'(cyc - prev), 32'd10);
         prev = cyc;
         @(posedge clk); #1;
         wait_done(n);
         chk($sformatf("rr done_id%0d", k), 32'(done_id), 32'(k % 2));
         chk($sformatf("rr q%0d", k), 32'(q), (k % 2 == 0) ? 32'h0E : 32'hF2);
      end
      @(negedge clk);
      req = 2'b00;
      repeat (12) @(posedge clk);

      // Reset in the fourth DIV cycle
      @(negedge clk);
      a0 = 8'd100; b0 = 8'd7;
      req = 2'b01;
      wait_gnt(n);
      chk("abort gnt", 32'(gnt), 32'd1);
      req = 2'b00;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      chk("abort gnt0",    32'(gnt),     32'd0);
      chk("abort busy",    32'(busy),    32'd0);
      chk("abort done",    32'(done),    32'd0);
      chk("abort done_id", 32'(done_id), 32'd0);
      chk("abort q",       32'(q),       32'd0);
      chk("abort r",       32'(r),       32'd0);
      chk("abort div0",    32'(div0),    32'd0);
      chk("abort ovf",     32'(ovf),     32'd0);
      ndone = 0;
      for (int i = 0; i < 15; i++) begin
         @(posedge clk); #1;
         if (done) ndone++;
      end
      chk("abort no_done", 32'(ndone), 32'd0);

      @(negedge clk);
      a1 = 8'(-100); b1 = 8'd7;
      req = 2'b11;
      wait_gnt(n);
      chk("post_rst gnt", 32'(gnt), 32'd1);
      req = 2'b00;
      @(posedge clk); #1;
      wait_done(n);
      chk("post_rst done_id", 32'(done_id), 32'd0);
      chk("post_rst q",       32'(q),       32'h0E);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/calc_div_ctrl.md
CALC_DIV_CTRL -- requirements
Module: calc_div_ctrl

Interface
REQ-001 SHALL have parameter DW, default 8, the operand, quotient and remainder width.
REQ-002 SHALL have port clk  input  1  the single clock, rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port req  input  2  request from requester 0 and requester 1, held high until the matching gnt bit.
REQ-005 SHALL have port a0 / b0  input  DW each  requester 0 signed dividend / divisor, held stable while req[0] is high.
REQ-006 SHALL have port a1 / b1  input  DW each  requester 1 signed dividend / divisor, held stable while req[1] is high.
REQ-007 SHALL have port gnt  output  2  one-cycle accept pulse, one-hot.
REQ-008 SHALL have port busy  output  1  high while a division is in progress.
REQ-009 SHALL have port done  output  1  one-cycle result-valid pulse.
REQ-010 SHALL have port done_id  output  1  index of the requester that owns the result.
REQ-011 SHALL have port q / r  output  DW each  signed quotient / signed remainder.
REQ-012 SHALL have port div0 / ovf  output  1 each  divide-by-zero flag / overflow flag.

Function
REQ-013 SHALL implement FSM states IDLE, DIV and FIX; busy SHALL be high exactly when the state is not IDLE.
REQ-014 IDLE with req != 0 at an edge SHALL do all of the following on that edge: choose a winner, latch |A|, |B|, both sign bits, the winner id and the B==0 condition, clear the iteration counter, set the matching gnt bit high for one cycle, and go to DIV.
REQ-015 Arbitration SHALL be round-robin: with both req bits high, the requester not served last SHALL win; after reset requester 0 SHALL have priority.
REQ-016 DIV SHALL resolve one quotient bit per cycle by restoring shift-subtract, using a DW+1-bit partial remainder, and SHALL run exactly DW cycles before going to FIX.
REQ-017 FIX SHALL apply the sign rules, register q, r, div0, ovf and done_id, pulse done for one cycle, and return to IDLE.
REQ-018 done SHALL rise exactly DW+1 cycles after gnt rises, and a new request SHALL be acceptable at the edge that ends the done cycle.
REQ-019 Sign rules: q SHALL truncate toward zero and be negative iff the operand signs differ and the magnitude is non-zero; r SHALL take the sign of the dividend, with |r| < |B|.
REQ-020 The magnitude of -2^(DW-1) SHALL be handled as unsigned 2^(DW-1); -128/1 SHALL give q=0x80, r=0.
REQ-021 For B==0, latency SHALL be unchanged, with q=0, r=A, div0=1 and ovf=0.
REQ-022 For A=-2^(DW-1) and B=-1, the result SHALL be q=0x7F, r=0, ovf=1 and div0=0.
REQ-023 q, r, div0, ovf and done_id SHALL hold their values until the next FIX cycle.
REQ-024 req SHALL be ignored while busy; a request raised during busy SHALL be served from IDLE with round-robin priority applied at that time.

Reset
REQ-025 rst_n low at an edge SHALL force IDLE, set gnt=0, busy=0, done=0, done_id=0, q=0, r=0, div0=0, ovf=0, and set the round-robin pointer to favour requester 0.
REQ-026 Reset during DIV or FIX SHALL abort the operation and SHALL produce no done pulse; the aborted request SHALL NOT be replayed.

Structure
REQ-027 The shared package calc_pkg SHALL hold the FSM state encoding, the default DW, and the iteration-count width constant.
REQ-028 Two-way round-robin arbitration SHALL be a sub-module named calc_rr_arb, with inputs req and an advance strobe and a one-hot grant output.
REQ-029 The shift-subtract datapath and the sign fix-up SHALL stay inside calc_div_ctrl.

Verification
REQ-030 The bench SHALL drive req=01 with a0=100, b0=7: gnt=01, done 9 cycles later, q=14, r=2, done_id=0, flags 0.
REQ-031 The bench SHALL cover sign combinations with requester 1: -100/7 -> q=-14 (0xF2), r=-2 (0xFE); 100/-7 -> q=-14, r=2; -100/-7 -> q=14, r=-2.
REQ-032 The bench SHALL cover the edge cases: 5/0 -> q=0, r=5, div0=1; -128/-1 -> q=0x7F, r=0, ovf=1; -128/1 -> q=0x80, r=0.
REQ-033 The bench SHALL hold req=11 continuously for four operations: grants SHALL alternate 01,10,01,10, with done_id matching each grant and no back-to-back gnt within 10 cycles.
REQ-034 The bench SHALL pulse rst_n low for one cycle at the fourth DIV cycle: no done pulse, all outputs 0, and the next req=11 grants requester 0.
